// File: rtl/apb_slv_pkg.sv
// Shared types and decode helper for the APB completer register bank.
// The error decode lives here so the top stays focused on the handshake.
package apb_slv_pkg;

  typedef enum logic {IDLE, ACCESS} apb_slv_state_e;

  localparam int STRB_W = 4;
  localparam int DATA_W = 32;

  // Word 0 is read-only; the upper half of the map is writable only by privileged masters.
  function automatic logic addr_err(input logic [31:0] addr, input logic write,
                                    input logic [2:0] prot, input int unsigned depth);
    logic [31:0] idx;
    idx = addr >> 2;
    return (addr[1:0] != 2'b00) ||
           (addr >= depth * 4) ||
           (write && (idx == 32'd0)) ||
           (write && !prot[0] && (idx >= depth / 2));
  endfunction

endpackage

// File: rtl/apb_slv_storage.sv
// DEPTH x 32-bit register file with byte-lane writes and async clear.
// Word 0 has no flops: it always reads back the constant ID_VALUE.
module apb_slv_storage
  import apb_slv_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] ID_VALUE = 32'hA5B2_0001,
  localparam int         IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [STRB_W-1:0] i_strb,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] w_words [DEPTH];

  assign w_words[0] = ID_VALUE;

  for (genvar g = 1; g < DEPTH; g++) begin : g_word
    logic [DATA_W-1:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= '0;
      end else if (i_we && (i_idx == IDX_W'(g))) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (i_strb[b]) r_word[8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end

    assign w_words[g] = r_word;
  end

  assign o_rdata = w_words[i_idx];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer: handshake FSM with programmable wait states, address decode
// and error response in front of the byte-enable register storage.
module apb_slave_regbank
  import apb_slv_pkg::*;
#(
  parameter int          ADDRWIDTH   = 16,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B2_0001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 psel,
  input  logic                 penable,
  input  logic [ADDRWIDTH-1:0] paddr,
  input  logic                 pwrite,
  input  logic [DATA_W-1:0]    pwdata,
  input  logic [STRB_W-1:0]    pstrb,
  input  logic [2:0]           pprot,
  output logic [DATA_W-1:0]    prdata,
  output logic                 pready,
  output logic                 pslverr
);

  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  apb_slv_state_e    r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              w_ready;
  logic              w_err;
  logic              w_we;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A select seen in IDLE always starts an access, even if penable is already high.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (psel) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!psel || (penable && w_ready)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != WAIT_C) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_ready = (r_state == ACCESS) && penable && (r_cnt == WAIT_C);
  assign w_idx   = paddr[IDX_W+1:2];
  assign w_err   = addr_err(32'(paddr), pwrite, pprot, DEPTH);
  assign w_we    = psel && penable && w_ready && pwrite && !w_err;

  apb_slv_storage #(
    .DEPTH    (DEPTH),
    .ID_VALUE (ID_VALUE)
  ) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_strb  (pstrb),
    .i_wdata (pwdata),
    .o_rdata (w_rdata)
  );

  assign pready  = w_ready;
  assign pslverr = w_err && w_ready;
  assign prdata  = (w_ready && !pwrite && !w_err) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: one wait-state instance plus a zero-wait instance
// sharing the bus, each selected by its own psel.
module tb_apb_slave_regbank;

  logic        clk;
  logic        rst_n;
  logic        psel1, psel0, penable;
  logic [15:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata1, prdata0;
  logic        pready1, pready0, pslverr1, pslverr0;

  int checks   = 0;
  int failures = 0;

  apb_slave_regbank #(
    .ADDRWIDTH(16), .DEPTH(16), .WAIT_CYCLES(1), .ID_VALUE(32'hA5B2_0001)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .psel(psel1), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  apb_slave_regbank #(
    .ADDRWIDTH(16), .DEPTH(16), .WAIT_CYCLES(0), .ID_VALUE(32'hA5B2_0001)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a rising edge; returns just after the completion edge with the bus idle,
  // so consecutive calls are back-to-back. cycles counts access cycles, -1 on timeout.
  task automatic xfer(input bit d0, input bit wr, input logic [15:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rdata, output logic err, output int cycles);
    psel1   = !d0;
    psel0   = d0;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    pprot   = prot;
    rdata   = '0;
    err     = 1'b0;
    cycles  = -1;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if ((d0 ? pready0 : pready1) === 1'b1) begin
        rdata  = d0 ? prdata0 : prdata1;
        err    = d0 ? pslverr0 : pslverr1;
        cycles = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel1   = 1'b0;
    psel0   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int cy;
    @(negedge clk);
    checks++;
    if (pready1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_pready: got %b expected 0", pready1); end
    checks++;
    if (pslverr1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_pslverr: got %b expected 0", pslverr1); end
    checks++;
    if (prdata1 !== 32'h0) begin failures++; $display("[TB] FAIL reset_prdata: got %h expected 0", prdata1); end
    @(posedge clk); #1;
    xfer(0, 0, 16'h0000, 32'h0, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (rd !== 32'hA5B2_0001) begin failures++; $display("[TB] FAIL reset_id: got %h expected a5b20001", rd); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int cy;
    xfer(0, 1, 16'h0004, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, cy);
    checks++;
    if (cy !== 2) begin failures++; $display("[TB] FAIL wr_latency: got %0d access cycles expected 2", cy); end
    checks++;
    if (er !== 1'b0) begin failures++; $display("[TB] FAIL wr_err: got %b expected 0", er); end
    xfer(0, 0, 16'h0004, 32'h0, 4'hF, 3'b000, rd, er, cy);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_04: got %h expected deadbeef", rd); end
    xfer(0, 1, 16'h0004, 32'hFFFFFFFF, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (er !== 1'b0) begin failures++; $display("[TB] FAIL strb0_err: got %b expected 0", er); end
    xfer(0, 0, 16'h0004, 32'h0, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL strb0_noop: got %h expected deadbeef", rd); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic er; int cy;
    xfer(0, 1, 16'h0008, 32'hAAAAAAAA, 4'hF, 3'b000, rd, er, cy);
    xfer(0, 1, 16'h0008, 32'h11223344, 4'b0101, 3'b000, rd, er, cy);
    xfer(0, 0, 16'h0008, 32'h0, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (rd !== 32'hAA22AA44) begin failures++; $display("[TB] FAIL strobe_merge: got %h expected aa22aa44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int cy;
    xfer(0, 1, 16'h0000, 32'h1, 4'hF, 3'b001, rd, er, cy);
    checks++;
    if (er !== 1'b1) begin failures++; $display("[TB] FAIL wr_id_err: got %b expected 1", er); end
    xfer(0, 0, 16'h0000, 32'h0, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (rd !== 32'hA5B2_0001 || er !== 1'b0) begin
      failures++; $display("[TB] FAIL id_after_wr: got %h/%b expected a5b20001/0", rd, er);
    end
    xfer(0, 0, 16'h0040, 32'h0, 4'h0, 3'b001, rd, er, cy);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("[TB] FAIL rd_oob: got %h/%b expected 00000000/1", rd, er);
    end
    xfer(0, 0, 16'h0006, 32'h0, 4'h0, 3'b001, rd, er, cy);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("[TB] FAIL rd_misaligned: got %h/%b expected 00000000/1", rd, er);
    end
  endtask

  task automatic test_privilege();
    logic [31:0] rd; logic er; int cy;
    xfer(0, 1, 16'h0020, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, cy);
    checks++;
    if (er !== 1'b1) begin failures++; $display("[TB] FAIL upper_unpriv_err: got %b expected 1", er); end
    xfer(0, 0, 16'h0020, 32'h0, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      failures++; $display("[TB] FAIL upper_unchanged: got %h/%b expected 00000000/0", rd, er);
    end
    xfer(0, 1, 16'h0020, 32'hCAFEF00D, 4'hF, 3'b001, rd, er, cy);
    checks++;
    if (er !== 1'b0) begin failures++; $display("[TB] FAIL upper_priv_err: got %b expected 0", er); end
    xfer(0, 0, 16'h0020, 32'h0, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (rd !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL upper_updated: got %h expected cafef00d", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int cy; bit sawReady;
    xfer(0, 1, 16'h000C, 32'h12345678, 4'hF, 3'b000, rd, er, cy);
    sawReady = 0;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000C;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    if (pready1 === 1'b1) sawReady = 1;
    @(posedge clk); #1;
    psel1 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pready1 !== 1'b0) sawReady = 1;
    end
    checks++;
    if (sawReady) begin failures++; $display("[TB] FAIL abort_pready: got 1 expected 0"); end
    @(posedge clk); #1;
    xfer(0, 0, 16'h000C, 32'h0, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (rd !== 32'h12345678 || cy !== 2) begin
      failures++; $display("[TB] FAIL abort_no_commit: got %h in %0d expected 12345678 in 2", rd, cy);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int cy;
    xfer(0, 1, 16'h0010, 32'h00000055, 4'hF, 3'b000, rd, er, cy);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0014;
    pwdata = 32'h000000AA; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pready1 !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_pready: got %b expected 1", pready1); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pready1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_abort_pready: got %b expected 0", pready1); end
    psel1 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 0, 16'h0010, 32'h0, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_clear_10: got %h expected 0", rd); end
    xfer(0, 0, 16'h0014, 32'h0, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_no_commit_14: got %h expected 0", rd); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic er; int cy;
    xfer(1, 1, 16'h0018, 32'h0BADF00D, 4'hF, 3'b000, rd, er, cy);
    checks++;
    if (cy !== 1 || er !== 1'b0) begin
      failures++; $display("[TB] FAIL w0_wr: got %0d cycles err %b expected 1 cycles err 0", cy, er);
    end
    xfer(1, 0, 16'h0018, 32'h0, 4'h0, 3'b000, rd, er, cy);
    checks++;
    if (cy !== 1 || rd !== 32'h0BADF00D) begin
      failures++; $display("[TB] FAIL w0_rd: got %h in %0d expected 0badf00d in 1", rd, cy);
    end
    xfer(1, 1, 16'h0000, 32'h1, 4'hF, 3'b001, rd, er, cy);
    checks++;
    if (cy !== 1 || er !== 1'b1) begin
      failures++; $display("[TB] FAIL w0_err: got %0d cycles err %b expected 1 cycles err 1", cy, er);
    end
  endtask

  initial begin
    rst_n = 1'b0; psel1 = 1'b0; psel0 = 1'b0; penable = 1'b0; paddr = '0;
    pwrite = 1'b0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_strobes();
    test_errors();
    test_privilege();
    test_abort();
    test_reset_mid_access();
    test_zero_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
